// File: rtl/ysyx_22050058_pipe_stage.sv
// ysyx_22050058_pipe_stage
//   Inter-stage pipeline register with a valid/ready handshake. With SKID=1 a second (skid)
//   entry lets in_ready depend only on registered state plus rst/flush. An empty stage drives
//   NOP_VALUE so downstream sees a bubble. Saturating stall/bubble/flush counters are included.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_data upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload (NOP_VALUE when not valid)
//   flush                     drop every held entry
//   occupancy                 number of valid entries held (0..2)
//   cnt_clr                   synchronous clear of all counters
//   stall_cnt/bubble_cnt/flush_cnt  saturating performance counters
module ysyx_22050058_pipe_stage #(
  parameter int unsigned     DW        = 64,
  parameter int unsigned     SKID      = 1,
  parameter logic [DW-1:0]   NOP_VALUE = '0,
  parameter int unsigned     CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic          main_valid_q;
  logic [DW-1:0] main_q;
  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic          push;
  logic          pop;

  // out_valid is gated by flush/rst so a flush cycle never transfers or counts as a stall.
  assign out_valid = main_valid_q & ~flush & ~rst;
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & in_ready;
  assign occupancy = rst ? 2'd0 : {main_valid_q & skid_valid, main_valid_q ^ skid_valid};

  if (SKID != 0) begin : g_skid
    logic          skid_valid_q;
    logic [DW-1:0] skid_q;

    assign in_ready   = ~rst & ~flush & ~skid_valid_q;
    assign skid_valid = skid_valid_q;
    assign skid_data  = skid_q;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        skid_valid_q <= 1'b0;
      end else if (pop) begin
        skid_valid_q <= 1'b0;
      end else if (push && main_valid_q) begin
        // Main is holding and not popping: park the new payload in the skid entry.
        skid_valid_q <= 1'b1;
        skid_q       <= in_data;
      end
    end
  end else begin : g_no_skid
    assign in_ready   = ~rst & ~flush & (~main_valid_q | out_ready);
    assign skid_valid = 1'b0;
    assign skid_data  = NOP_VALUE;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid_q <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        // in_ready was low, so no push can collide with the skid refill.
        main_q <= skid_data;
      end else begin
        main_valid_q <= push;
        if (push) main_q <= in_data;
      end
    end else if (push && !main_valid_q) begin
      main_valid_q <= 1'b1;
      main_q       <= in_data;
    end
  end

  // Performance counters
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             stall_inc, bubble_inc, flush_inc;

  assign stall_inc  = out_valid & ~out_ready;
  assign bubble_inc = ~out_valid & out_ready & ~rst;
  assign flush_inc  = flush & ~rst & (main_valid_q | skid_valid);

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (cnt_clr) begin
      stall_d  = '0;
      bubble_d = '0;
      flush_d  = '0;
    end else begin
      if (stall_inc && !(&stall_q))   stall_d  = stall_q + 1'b1;
      if (bubble_inc && !(&bubble_q)) bubble_d = bubble_q + 1'b1;
      if (flush_inc && !(&flush_q))   flush_d  = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  // Counters read as zero for the whole reset window, including its first cycle.
  assign stall_cnt  = rst ? '0 : stall_q;
  assign bubble_cnt = rst ? '0 : bubble_q;
  assign flush_cnt  = rst ? '0 : flush_q;

endmodule
